// File: rtl/prefix_adder_bk_pipe_pkg.sv
// Shared carry-tree helpers for the parallel-prefix adder family.
// Cell functions operate on {p, g} pairs with p in bit 1 and g in bit 0.
package prefix_pkg;

    function automatic int bk_levels(input int w);
        return 2 * $clog2(w) - 1;
    endfunction

    // Combine a high group with the adjacent lower group.
    function automatic logic [1:0] black_op(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] & lo[1], hi[0] | (hi[1] & lo[0])};
    endfunction

    function automatic logic gray_op(input logic [1:0] hi, input logic [1:0] lo);
        return hi[0] | (hi[1] & lo[0]);
    endfunction

endpackage

// File: rtl/prefix_adder_bk_pipe_tree.sv
// Combinational Brent-Kung prefix network. With SPLIT=1 the down-sweep takes its
// inputs from dn_p/dn_g so a pipeline register can sit between the two sweeps.
module bk_prefix_tree
    import prefix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit SPLIT = 1'b1
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] up_p,
    output logic [WIDTH-1:0] up_g,
    input  logic [WIDTH-1:0] dn_p,
    input  logic [WIDTH-1:0] dn_g,
    output logic [WIDTH-1:0] grp_g
);

    localparam int UP_LEVELS   = $clog2(WIDTH);
    localparam int DOWN_LEVELS = bk_levels(WIDTH) - UP_LEVELS;

    logic [WIDTH-1:0] src_p;
    logic [WIDTH-1:0] src_g;

    assign src_p = SPLIT ? dn_p : up_p;
    assign src_g = SPLIT ? dn_g : up_g;

    // Cells updated at a level never feed another cell of the same level, so in-place update is safe.
    always_comb begin : up_sweep
        logic [WIDTH-1:0] lp;
        logic [WIDTH-1:0] lg;
        lp = p;
        lg = g;
        for (int k = 0; k < UP_LEVELS; k++) begin
            for (int i = 0; i < WIDTH; i++) begin
                int lo;
                lo = (i >= (1 << k)) ? i - (1 << k) : 0;
                if (((i + 1) % (1 << (k + 1))) == 0) begin
                    {lp[i], lg[i]} = black_op({lp[i], lg[i]}, {lp[lo], lg[lo]});
                end
            end
        end
        up_p = lp;
        up_g = lg;
    end

    always_comb begin : down_sweep
        logic [WIDTH-1:0] dg;
        dg = src_g;
        for (int k = DOWN_LEVELS - 1; k >= 0; k--) begin
            for (int i = 0; i < WIDTH; i++) begin
                int lo;
                lo = (i >= (1 << k)) ? i - (1 << k) : 0;
                if ((((i + 1) % (1 << (k + 1))) == (1 << k)) && (i >= (1 << (k + 1)))) begin
                    dg[i] = gray_op({src_p[i], dg[i]}, {1'b0, dg[lo]});
                end
            end
        end
        grp_g = dg;
    end

endmodule

// File: rtl/prefix_adder_bk_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with tag sideband and a
// single global advance: the whole pipe moves together or holds together.
module prefix_adder_bk_pipe
    import prefix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic [TAG_W-1:0] tag_o
);

    if (WIDTH < 4 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("prefix_adder_bk_pipe: WIDTH must be a power of two in 4..128");
    end
    if (TAG_W < 1) begin : g_tag_check
        $error("prefix_adder_bk_pipe: TAG_W must be at least 1");
    end

    logic adv;
    assign adv     = !valid_o | ready_i;
    assign ready_o = adv;

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] pre_p;
    logic [WIDTH-1:0] pre_g;
    logic             cin;

    // Carry-in is folded into bit 0 generate so the tree needs no extra column.
    always_comb begin
        bb       = b_i ^ {WIDTH{sub_i}};
        cin      = sub_i | carry_i;
        pre_p    = a_i ^ bb;
        pre_g    = a_i & bb;
        pre_g[0] = pre_g[0] | (pre_p[0] & cin);
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_cin;
    logic             s1_a_msb;
    logic             s1_b_msb;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
            s1_tag   <= '0;
        end else if (adv) begin
            s1_valid <= valid_i;
            s1_p     <= pre_p;
            s1_g     <= pre_g;
            s1_cin   <= cin;
            s1_a_msb <= a_i[WIDTH-1];
            s1_b_msb <= bb[WIDTH-1];
            s1_tag   <= tag_i;
        end
    end

    logic [WIDTH-1:0] up_p;
    logic [WIDTH-1:0] up_g;
    logic [WIDTH-1:0] grp_g;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_p;
    logic [WIDTH-1:0] s2_g;
    logic [WIDTH-1:0] s2_h;
    logic             s2_cin;
    logic             s2_a_msb;
    logic             s2_b_msb;
    logic [TAG_W-1:0] s2_tag;

    bk_prefix_tree #(
        .WIDTH(WIDTH),
        .SPLIT(1'b1)
    ) u_tree (
        .p    (s1_p),
        .g    (s1_g),
        .up_p (up_p),
        .up_g (up_g),
        .dn_p (s2_p),
        .dn_g (s2_g),
        .grp_g(grp_g)
    );

    // The half-sum is the bit-level propagate captured before the up-sweep rewrites it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_g     <= '0;
            s2_h     <= '0;
            s2_cin   <= 1'b0;
            s2_a_msb <= 1'b0;
            s2_b_msb <= 1'b0;
            s2_tag   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_p     <= up_p;
            s2_g     <= up_g;
            s2_h     <= s1_p;
            s2_cin   <= s1_cin;
            s2_a_msb <= s1_a_msb;
            s2_b_msb <= s1_b_msb;
            s2_tag   <= s1_tag;
        end
    end

    logic [WIDTH-1:0] sum_next;
    logic             carry_next;
    logic             ovf_next;

    always_comb begin
        sum_next   = s2_h ^ {grp_g[WIDTH-2:0], s2_cin};
        carry_next = grp_g[WIDTH-1];
        ovf_next   = (s2_a_msb == s2_b_msb) & (sum_next[WIDTH-1] != s2_a_msb);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            sum_o   <= '0;
            carry_o <= 1'b0;
            ovf_o   <= 1'b0;
            tag_o   <= '0;
        end else if (adv) begin
            valid_o <= s2_valid;
            sum_o   <= sum_next;
            carry_o <= carry_next;
            ovf_o   <= ovf_next;
            tag_o   <= s2_tag;
        end
    end

endmodule

// File: tb/tb_prefix_adder_bk_pipe.sv
// Directed-vector and randomised checks for the pipelined Brent-Kung adder,
// including back-pressure and mid-stream reset sequences.
module tb_prefix_adder_bk_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int NV = 10;
    localparam int N_RAND = 400;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          cin;
        logic          sub;
        logic [TW-1:0] tag;
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          carry_i;
    logic          sub_i;
    logic [TW-1:0] tag_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  sum_o;
    logic          carry_o;
    logic          ovf_o;
    logic [TW-1:0] tag_o;

    int checks = 0;
    int errors = 0;

    vec_t vecs[NV];
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    prefix_adder_bk_pipe #(
        .WIDTH(W),
        .TAG_W(TW)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .a_i    (a_i),
        .b_i    (b_i),
        .carry_i(carry_i),
        .sub_i  (sub_i),
        .tag_i  (tag_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .sum_o  (sum_o),
        .carry_o(carry_o),
        .ovf_o  (ovf_o),
        .tag_o  (tag_o)
    );

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s, input logic [TW-1:0] t);
        valid_i = v;
        a_i     = a;
        b_i     = b;
        carry_i = c;
        sub_i   = s;
        tag_i   = t;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: plain wide addition of the (possibly inverted) operand.
    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s, input logic [TW-1:0] t);
        exp_t         e;
        logic [W-1:0] bb;
        logic [W:0]   r;
        bb     = s ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s | c)};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        e.tag  = t;
        return e;
    endfunction

    initial begin
        exp_t e;
        int   sent;
        int   recv;
        int   cyc;
        logic stale;
        logic v;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'h1, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 4'h2, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'h3, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'hA, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 4'h5, 32'h23456789, 1'b0, 1'b0};
        vecs[5] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 4'h6, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 4'h7, 32'h0000000D, 1'b1, 1'b0};
        vecs[7] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 4'h8, 32'h00000000, 1'b1, 1'b0};
        vecs[8] = '{32'h40000000, 32'h40000000, 1'b0, 1'b0, 4'h9, 32'h80000000, 1'b0, 1'b1};
        vecs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 4'hB, 32'hFFFFFFFF, 1'b1, 1'b0};

        rst_i   = 1'b1;
        ready_i = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("reset_valid_o", 64'(valid_o), 64'd0);
        checkOutput("reset_sum_o", 64'(sum_o), 64'd0);
        checkOutput("reset_carry_o", 64'(carry_o), 64'd0);
        checkOutput("reset_ovf_o", 64'(ovf_o), 64'd0);
        checkOutput("reset_tag_o", 64'(tag_o), 64'd0);
        checkOutput("reset_ready_o", 64'(ready_o), 64'd1);

        // One op at a time: result must appear exactly three edges after accept.
        for (int n = 0; n < NV; n++) begin
            @(negedge clk_i);
            applyStimulus(1'b1, vecs[n].a, vecs[n].b, vecs[n].cin, vecs[n].sub, vecs[n].tag);
            @(negedge clk_i);
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
            @(negedge clk_i);
            checkOutput($sformatf("latency_v%0d", n), 64'(valid_o), 64'd0);
            @(negedge clk_i);
            checkOutput($sformatf("valid_v%0d", n), 64'(valid_o), 64'd1);
            checkOutput($sformatf("sum_v%0d", n), 64'(sum_o), 64'(vecs[n].sum));
            checkOutput($sformatf("carry_v%0d", n), 64'(carry_o), 64'(vecs[n].cout));
            checkOutput($sformatf("ovf_v%0d", n), 64'(ovf_o), 64'(vecs[n].ovf));
            checkOutput($sformatf("tag_v%0d", n), 64'(tag_o), 64'(vecs[n].tag));
        end

        // Back-pressure with three ops in flight.
        @(negedge clk_i);
        applyStimulus(1'b1, 32'h100, 32'h1, 1'b0, 1'b0, 4'h1);
        @(negedge clk_i);
        applyStimulus(1'b1, 32'h200, 32'h2, 1'b0, 1'b0, 4'h2);
        @(negedge clk_i);
        applyStimulus(1'b1, 32'h300, 32'h3, 1'b0, 1'b0, 4'h3);
        @(negedge clk_i);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
        ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checkOutput($sformatf("bp_ready_o_c%0d", c), 64'(ready_o), 64'd0);
            checkOutput($sformatf("bp_valid_o_c%0d", c), 64'(valid_o), 64'd1);
            checkOutput($sformatf("bp_tag_o_c%0d", c), 64'(tag_o), 64'd1);
            checkOutput($sformatf("bp_sum_o_c%0d", c), 64'(sum_o), 64'h101);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("bp_rel_valid2", 64'(valid_o), 64'd1);
        checkOutput("bp_rel_tag2", 64'(tag_o), 64'd2);
        checkOutput("bp_rel_sum2", 64'(sum_o), 64'h202);
        @(negedge clk_i);
        checkOutput("bp_rel_valid3", 64'(valid_o), 64'd1);
        checkOutput("bp_rel_tag3", 64'(tag_o), 64'd3);
        checkOutput("bp_rel_sum3", 64'(sum_o), 64'h303);
        @(negedge clk_i);
        checkOutput("bp_rel_drained", 64'(valid_o), 64'd0);

        // Reset while three ops are in flight.
        @(negedge clk_i);
        applyStimulus(1'b1, 32'h400, 32'h4, 1'b0, 1'b0, 4'h4);
        @(negedge clk_i);
        applyStimulus(1'b1, 32'h500, 32'h5, 1'b1, 1'b0, 4'h5);
        @(negedge clk_i);
        applyStimulus(1'b1, 32'hF00, 32'h6, 1'b0, 1'b1, 4'h6);
        @(negedge clk_i);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
        checkOutput("pre_rst_valid", 64'(valid_o), 64'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkOutput("mid_rst_valid_o", 64'(valid_o), 64'd0);
        checkOutput("mid_rst_sum_o", 64'(sum_o), 64'd0);
        checkOutput("mid_rst_carry_o", 64'(carry_o), 64'd0);
        checkOutput("mid_rst_ovf_o", 64'(ovf_o), 64'd0);
        checkOutput("mid_rst_tag_o", 64'(tag_o), 64'd0);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (valid_o) stale = 1'b1;
        end
        checkOutput("mid_rst_no_stale", 64'(stale), 64'd0);

        // Random traffic with random back-pressure against the reference model.
        sent = 0;
        recv = 0;
        cyc  = 0;
        while ((sent < N_RAND || exp_q.size() > 0) && cyc < 20000) begin
            @(negedge clk_i);
            v = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
            applyStimulus(v, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          TW'($urandom));
            ready_i = ($urandom_range(0, 3) != 0);
            #1;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rand_unexpected_valid", 64'(valid_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("rand_result_%0d", recv),
                                64'({tag_o, ovf_o, carry_o, sum_o}),
                                64'({e.tag, e.ovf, e.cout, e.sum}));
                    recv++;
                end
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(ref_model(a_i, b_i, carry_i, sub_i, tag_i));
                sent++;
            end
            cyc++;
        end
        checkOutput("rand_timeout", 64'(cyc >= 20000), 64'd0);
        checkOutput("rand_count", 64'(recv), 64'(N_RAND));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
